// File: rtl/bcd_seg7_scan_pkg.sv
// bcd_seg7_scan_pkg: scan states, seven-segment glyph table and helpers
package bcd_seg7_scan_pkg;
  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  // {g,f,e,d,c,b,a} active-high, indexed by nibble; 10..15 render as a dash
  localparam logic [15:0][6:0] GLYPHS = {{6{SEG_DASH}}, 7'h6F, 7'h7F, 7'h07, 7'h7D,
                                          7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-high seven-segment glyph
module seg7_decode
  import bcd_seg7_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  assign glyph = GLYPHS[nib];
endmodule

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: tear-free four-digit multiplexed seven-segment scanner with blanking gaps
module bcd_seg7_scan
  import bcd_seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int BLANK_LZ    = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame
);
  localparam int CW = $clog2(max2(REFRESH_DIV, BLANK_CYC));
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic LZ = BLANK_LZ != 0;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] digit, digit_n;
  logic [15:0] sh_bcd, disp, disp_n;
  logic [3:0] sh_dp, disp_dp, disp_dp_n, lz;
  logic [6:0] glyph, seg_n;
  logic load, blanked, dot, on;
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    digit_n = digit;
    if (!en) begin
      state_n = OFF;
      cnt_n = '0;
      digit_n = '0;
    end else if (state == OFF) begin
      state_n = BLANK;
      cnt_n = '0;
      digit_n = '0;
    end else if (state == BLANK && cnt == CW'(BLANK_CYC - 1)) begin
      state_n = DRIVE;
      cnt_n = '0;
    end else if (state == DRIVE && cnt == CW'(REFRESH_DIV - 1)) begin
      state_n = BLANK;
      cnt_n = '0;
      digit_n = digit + 2'd1;
    end
  end
  // frame boundary: entering DRIVE of digit 0; a coincident strobe bypasses the shadow
  assign load      = state_n == DRIVE && state != DRIVE && digit_n == 2'd0;
  assign disp_n    = load ? (bcd_valid ? bcd_in : sh_bcd) : disp;
  assign disp_dp_n = load ? (bcd_valid ? dp_in : sh_dp) : disp_dp;
  assign lz[3] = LZ && disp_n[15:12] == 4'd0;
  assign lz[2] = lz[3] && disp_n[11:8] == 4'd0;
  assign lz[1] = lz[2] && disp_n[7:4] == 4'd0;
  assign lz[0] = 1'b0;
  assign blanked = lz[digit_n];
  assign dot     = disp_dp_n[digit_n];
  assign on      = state_n == DRIVE && (!blanked || dot);
  assign seg_n   = state_n == DRIVE && !blanked ? glyph : SEG_OFF;
  seg7_decode u_dec (.nib(disp_n[{digit_n, 2'b00} +: 4]), .glyph(glyph));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt <= '0;
      digit <= '0;
      sh_bcd <= '0;
      sh_dp <= '0;
      disp <= '0;
      disp_dp <= '0;
      seg <= {7{AL}};
      dp <= AL;
      an <= {4{AL}};
      frame <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      digit <= digit_n;
      if (bcd_valid) begin
        sh_bcd <= bcd_in;
        sh_dp <= dp_in;
      end
      disp <= disp_n;
      disp_dp <= disp_dp_n;
      seg <= seg_n ^ {7{AL}};
      dp <= (on && dot) ^ AL;
      an <= ({3'b000, on} << digit_n) ^ {4{AL}};
      frame <= load;
    end
  end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: directed frame-by-frame checks of the scanner with short dwell
module tb_bcd_seg7_scan;
  logic clk = 1'b0, rst = 1'b1, bcd_valid = 1'b0, en = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0] dp_in = '0, an;
  logic [6:0] seg;
  logic dp, frame;
  int n_checks = 0, n_fail = 0;

  bcd_seg7_scan #(.REFRESH_DIV(4), .BLANK_CYC(1), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid), .dp_in(dp_in),
    .en(en), .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in = d;
    bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 40 && frame !== 1'b1; i++) tick();
    if (frame !== 1'b1) check("frame_timeout", 16'(frame), 16'd1);
  endtask

  // outputs packed as {frame, an, dp, seg}; g* are active-high glyphs, m = driven anodes
  task automatic expect_frame(input string tag, input logic [6:0] g3, input logic [6:0] g2,
                              input logic [6:0] g1, input logic [6:0] g0,
                              input logic [3:0] m, input logic [3:0] d);
    logic [6:0] g [4];
    logic [3:0] a;
    logic [12:0] exp;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    wait_frame();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 5; c++) begin
        a = m[k] ? ~(4'b0001 << k) : 4'hF;
        exp = c == 4 ? {1'b0, 4'hF, 1'b1, 7'h7F} : {k == 0 && c == 0, a, ~(m[k] & d[k]), ~g[k]};
        check($sformatf("%s_d%0d_c%0d", tag, k, c), {3'b000, frame, an, dp, seg}, {3'b000, exp});
        tick();
      end
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(dp), 16'd1);
    check("rst_frame", 16'(frame), 16'd0);
    rst = 1'b0;
    en = 1'b1;
    tick();
    check("start_blank", {11'd0, frame, an}, {11'd0, 1'b0, 4'hF});
    tick();
    check("start_d0", {11'd0, frame, an}, {11'd0, 1'b1, 4'hE});
    expect_frame("zero", 7'h00, 7'h00, 7'h00, 7'h3F, 4'b0001, 4'b0000);
    check("frame_period", 16'(frame), 16'd1);
    strobe(16'h1234, 4'b0100);
    expect_frame("n1234", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b1111, 4'b0100);
    strobe(16'h0070, 4'b0000);
    tick();
    strobe(16'h0305, 4'b0000);
    expect_frame("n0305", 7'h00, 7'h4F, 7'h3F, 7'h6D, 4'b0111, 4'b0000);
    for (int i = 0; i < 19; i++) tick();
    strobe(16'h9999, 4'b0000);
    expect_frame("n9999", 7'h6F, 7'h6F, 7'h6F, 7'h6F, 4'b1111, 4'b0000);
    strobe(16'h00A0, 4'b0000);
    expect_frame("dash", 7'h00, 7'h00, 7'h40, 7'h3F, 4'b0011, 4'b0000);
    strobe(16'h1234, 4'b0000);
    wait_frame();
    for (int i = 0; i < 11; i++) tick();
    check("mid_d2", 16'(an), 16'hB);
    en = 1'b0;
    tick();
    check("en_off_an", 16'(an), 16'hF);
    check("en_off_seg", 16'(seg), 16'h7F);
    tick();
    tick();
    check("en_off_hold", 16'(an), 16'hF);
    en = 1'b1;
    tick();
    check("reen_blank", {11'd0, frame, an}, {11'd0, 1'b0, 4'hF});
    tick();
    check("reen_d0", {11'd0, frame, an}, {11'd0, 1'b1, 4'hE});
    check("reen_seg", 16'(seg), 16'h7F & ~16'h66);
    tick();
    rst = 1'b1;
    #1;
    check("arst_an", 16'(an), 16'hF);
    check("arst_seg", 16'(seg), 16'h7F);
    check("arst_dp", 16'(dp), 16'd1);
    tick();
    rst = 1'b0;
    tick();
    check("rel_blank", 16'(an), 16'hF);
    tick();
    check("rel_d0", {11'd0, frame, an}, {11'd0, 1'b1, 4'hE});
    check("rel_seg", 16'(seg), 16'h40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
